// File: rtl/spi_cmd_sched.sv
// Two-requester SPI command master: round-robin arbitration, then one
// 8-bit frame {start=0, op[2:0], data[3:0]} shifted MSB first on ss/sclk/mosi.
module spi_cmd_sched #(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [3:0] data0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [3:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       err,
  output logic       done,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int CNT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IDLE_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             half_q, half_d;     // 0 = sclk high half, 1 = low half
  logic             launch_q, launch_d; // grant cycle: frame latched, gnt visible
  logic [7:0]       frame_q, frame_d;
  logic             rr_q, rr_d;         // last winner
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic             ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;

  logic arb_window, win0, win1, frame_legal, fall_cycle;

  // Arbitration happens in idle and in the last gap cycle, so a waiting
  // request is granted in the very first idle cycle after the gap.
  assign arb_window  = ((state_q == IDLE) && !launch_q) ||
                       ((state_q == GAP) && (cnt_q == GAP_LAST));
  assign win0        = arb_window && req0 && (!req1 || rr_q);
  assign win1        = arb_window && req1 && (!req0 || !rr_q);
  assign frame_legal = (frame_q[6:4] == 3'b100) || (frame_q[6:4] == 3'b110);
  assign fall_cycle  = (state_q == SHIFT) && half_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      launch_q <= 1'b0;
      frame_q  <= '0;
      rr_q     <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ss_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      launch_q <= launch_d;
      frame_q  <= frame_d;
      rr_q     <= rr_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ss_q     <= ss_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    half_d   = half_q;
    launch_d = launch_q;
    frame_d  = frame_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (launch_q) begin
          launch_d = 1'b0;
          cnt_d    = '0;
          state_d  = frame_legal ? SETUP : GAP;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == 3'd7) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 3'd1;
            half_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (win0 || win1) begin
      launch_d = 1'b1;
      frame_d  = win0 ? {1'b0, op0, data0} : {1'b0, op1, data1};
      rr_d     = win1;
    end
  end

  always_comb begin
    gnt0_d = win0;
    gnt1_d = win1;
    err_d  = (state_q == IDLE) && launch_q && !frame_legal;
    done_d = (state_d == HOLD) && (cnt_d == DIV_LAST);
    busy_d = (state_d != IDLE);
    ss_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    sclk_d = (state_d == SHIFT) && !half_d;
    mosi_d = mosi_q;
    // mosi moves one clk after each sclk fall; after the 8th fall it idles high
    if ((state_q == IDLE) && launch_q && frame_legal) begin
      mosi_d = frame_q[7];
    end else if (fall_cycle) begin
      mosi_d = (bit_q == 3'd7) ? 1'b1 : frame_q[3'd6 - bit_q];
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;
  assign ss   = ss_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule
